debounce_edge: RTL

Glitch filter and edge detector that sits directly downstream of the single-bit D flip-flop capture stage. It consumes that stage's registered output `q` on `d_in`. It accepts a level change only after the new value has held for `STABLE_CYCLES` consecutive clock edges. It then produces a clean level, one-cycle rise/fall pulses, a glitch-rejected pulse and, optionally, a count of accepted transitions.

---
 rtl/debounce_edge.sv | 92 +++++++++
 1 files changed

// File: rtl/debounce_edge.sv
// debounce_edge: glitch filter and edge detector on a registered level; edge_cnt built only with DEBOUNCE_EDGE_COUNT_EN.
module debounce_edge #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter logic        INIT_LEVEL    = 1'b0,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_in,
    input  logic             cnt_clr,
    output logic             level_out,
    output logic             rise,
    output logic             fall,
    output logic             glitch,
    output logic [CNT_W-1:0] edge_cnt
);
    typedef enum logic {IDLE, CHECK} state_t;
    localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       d_q, level_q, level_d;
    logic       rise_q, rise_d, fall_q, fall_d, glitch_q, glitch_d;
    logic       acc;
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q      <= INIT_LEVEL;
            level_q  <= INIT_LEVEL;
            state_q  <= IDLE;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            d_q      <= d_in;
            level_q  <= level_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = 1'b0;
        acc      = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = (d_q != level_q) ? CHECK : IDLE;
                cnt_d   = (d_q != level_q) ? 8'd1 : 8'd0;
            end
            CHECK: begin
                if (d_q == level_q) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    glitch_d = 1'b1;
                end else if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = ~level_q;
                    rise_d  = ~level_q;
                    fall_d  = level_q;
                    acc     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign level_out = level_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign glitch    = glitch_q;
`ifdef DEBOUNCE_EDGE_COUNT_EN
    logic [CNT_W-1:0] edge_cnt_q;
    // Clear outranks a coincident acceptance.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) edge_cnt_q <= '0;
        else if (acc) edge_cnt_q <= edge_cnt_q + 1'b1;
    end
    assign edge_cnt = edge_cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = ^{cnt_clr, acc};
    assign edge_cnt   = '0;
`endif
endmodule
